// File: rtl/pt_decode_stream.sv
// Plaintext decode engine: recovers round(x/DELTA) mod T per phase coefficient
// using a bit-serial restoring divider, with index/last framing and sticky error flags.
module pt_decode_stream #(
    parameter int unsigned N      = 4,
    parameter int unsigned W      = 11,
    parameter int unsigned QP     = 1024,
    parameter int unsigned DELTAP = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_coef,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_coef,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 err_range,
    output logic                 err_frame,
    input  logic                 err_clr
);
    localparam int unsigned TP = QP / DELTAP;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(W + 2);

    typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

    state_t        state, state_d;
    logic          in_ready_d, out_valid_d, out_last_d, last_q, last_q_d;
    logic [W-1:0]  out_coef_d;
    logic [IW-1:0] out_idx_d, idx, idx_d;
    logic [W:0]    dvd, dvd_d, rem, rem_d, quo, quo_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          err_range_d, err_frame_d;

    logic [W+1:0]  trial;
    logic          qbit;
    logic [W:0]    rem_nx, quo_nx, quo_wr;
    logic          idx_end;

    // One restoring-division step plus the single conditional wrap into [0,T)
    always_comb begin
        trial   = {rem, dvd[W]};
        qbit    = (trial >= (W+2)'(DELTAP));
        rem_nx  = qbit ? (W+1)'(trial - (W+2)'(DELTAP)) : (W+1)'(trial);
        quo_nx  = {quo[W-1:0], qbit};
        quo_wr  = (quo_nx >= (W+1)'(TP)) ? (quo_nx - (W+1)'(TP)) : quo_nx;
        idx_end = (idx == IW'(N - 1));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state;
        out_valid_d = out_valid;
        out_coef_d  = out_coef;
        out_last_d  = out_last;
        out_idx_d   = out_idx;
        idx_d       = idx;
        last_q_d    = last_q;
        dvd_d       = dvd;
        rem_d       = rem;
        quo_d       = quo;
        cnt_d       = cnt;
        err_range_d = err_clr ? 1'b0 : err_range;
        err_frame_d = err_clr ? 1'b0 : err_frame;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Out-of-range phase divides a zero dividend, yielding 0
                    if ({1'b0, in_coef} >= (W+1)'(QP)) begin
                        err_range_d = 1'b1;
                        dvd_d       = '0;
                    end else begin
                        dvd_d = {1'b0, in_coef} + (W+1)'(DELTAP / 2);
                    end
                    if (in_last != idx_end) begin
                        err_frame_d = 1'b1;
                    end
                    last_q_d = in_last;
                    rem_d    = '0;
                    quo_d    = '0;
                    cnt_d    = '0;
                    state_d  = DIV;
                end
            end
            DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                dvd_d = {dvd[W-1:0], 1'b0};
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(W)) begin
                    out_coef_d  = W'(quo_wr);
                    out_idx_d   = idx;
                    out_last_d  = idx_end;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    // An early in_last realigns the next frame to slot 0
                    idx_d       = (idx_end || last_q) ? '0 : idx + IW'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_coef  <= '0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            idx       <= '0;
            last_q    <= 1'b0;
            dvd       <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            err_range <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_coef  <= out_coef_d;
            out_last  <= out_last_d;
            out_idx   <= out_idx_d;
            idx       <= idx_d;
            last_q    <= last_q_d;
            dvd       <= dvd_d;
            rem       <= rem_d;
            quo       <= quo_d;
            cnt       <= cnt_d;
            err_range <= err_range_d;
            err_frame <= err_frame_d;
        end
    end
endmodule

// File: tb/tb_pt_decode_stream.sv
// Directed bench for pt_decode_stream with Q=1024, DELTA=16, T=64, W=11, N=4.
module tb_pt_decode_stream;
    localparam int unsigned N = 4;
    localparam int unsigned W = 11;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, in_last, out_valid, out_ready;
    logic         out_last, err_range, err_frame, err_clr;
    logic [W-1:0] in_coef, out_coef;
    logic [1:0]   out_idx;

    int checks = 0;
    int errors = 0;

    pt_decode_stream #(.N(N), .W(W), .QP(1024), .DELTAP(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
        .out_last(out_last), .out_idx(out_idx),
        .err_range(err_range), .err_frame(err_frame), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Send one coefficient, check latency and result, optionally stall, then accept it
    task automatic xfer(input logic [W-1:0] coef, input logic last, input logic clr,
                        input logic [W-1:0] expc, input logic [1:0] eidx,
                        input logic elast, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_coef  = coef;
        in_last  = last;
        err_clr  = clr;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        err_clr  = 1'b0;
        chk("busy_in_ready", 32'(in_ready), 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        // Handshake cycle counts as cycle 1, so out_valid is high in cycle W+2
        chk("latency", 32'(n + 1), W + 2);
        chk("out_coef", 32'(out_coef), 32'(expc));
        chk("out_idx", 32'(out_idx), 32'(eidx));
        chk("out_last", 32'(out_last), 32'(elast));
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_coef", 32'(out_coef), 32'(expc));
            chk("hold_idx", 32'(out_idx), 32'(eidx));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 0);
        chk("ready_back", 32'(in_ready), 1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; in_coef = '0; in_last = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_coef", 32'(out_coef), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_err_range", 32'(err_range), 0);
        chk("rst_err_frame", 32'(err_frame), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_in_ready", 32'(in_ready), 1);

        // Rounding, also a correctly framed frame
        xfer(11'd0,  1'b0, 1'b0, 11'd0, 2'd0, 1'b0, 0);
        xfer(11'd7,  1'b0, 1'b0, 11'd0, 2'd1, 1'b0, 0);
        xfer(11'd8,  1'b0, 1'b0, 11'd1, 2'd2, 1'b0, 0);
        xfer(11'd33, 1'b1, 1'b0, 11'd2, 2'd3, 1'b1, 0);
        chk("frame_ok", 32'(err_frame), 0);

        // Wrap at T and top of range
        xfer(11'd1016, 1'b0, 1'b0, 11'd0,  2'd0, 1'b0, 0);
        xfer(11'd1000, 1'b0, 1'b0, 11'd63, 2'd1, 1'b0, 0);
        xfer(11'd100,  1'b0, 1'b0, 11'd6,  2'd2, 1'b0, 0);
        xfer(11'd200,  1'b1, 1'b0, 11'd13, 2'd3, 1'b1, 0);
        chk("frame_ok2", 32'(err_frame), 0);

        // Early in_last on slot 1: error and realign to slot 0
        xfer(11'd16, 1'b0, 1'b0, 11'd1, 2'd0, 1'b0, 0);
        xfer(11'd32, 1'b1, 1'b0, 11'd2, 2'd1, 1'b0, 0);
        chk("frame_err", 32'(err_frame), 1);
        xfer(11'd48, 1'b0, 1'b0, 11'd3, 2'd0, 1'b0, 0);
        chk("frame_err_sticky", 32'(err_frame), 1);
        pulse_clr();
        chk("frame_err_clr", 32'(err_frame), 0);
        xfer(11'd64, 1'b0, 1'b0, 11'd4, 2'd1, 1'b0, 0);
        xfer(11'd80, 1'b0, 1'b0, 11'd5, 2'd2, 1'b0, 0);
        xfer(11'd96, 1'b1, 1'b0, 11'd6, 2'd3, 1'b1, 0);

        // Backpressure for 20 cycles in HOLD, then a single transfer
        xfer(11'd160, 1'b0, 1'b0, 11'd10, 2'd0, 1'b0, 20);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("single_transfer", 32'(seen), 0);

        // Range error, clear, then clear coincident with a new bad input
        xfer(11'd1030, 1'b0, 1'b0, 11'd0, 2'd1, 1'b0, 0);
        chk("range_err", 32'(err_range), 1);
        pulse_clr();
        chk("range_err_clr", 32'(err_range), 0);
        xfer(11'd2000, 1'b0, 1'b1, 11'd0, 2'd2, 1'b0, 0);
        chk("range_err_wins", 32'(err_range), 1);
        xfer(11'd1023, 1'b1, 1'b0, 11'd0, 2'd3, 1'b1, 0);
        xfer(11'd500,  1'b0, 1'b0, 11'd31, 2'd0, 1'b0, 0);

        // Asynchronous reset in the middle of a division
        in_valid = 1'b1; in_coef = 11'd300; in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_coef", 32'(out_coef), 0);
        chk("arst_out_idx", 32'(out_idx), 0);
        chk("arst_out_last", 32'(out_last), 0);
        chk("arst_err_range", 32'(err_range), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_out_after_reset", 32'(seen), 0);
        xfer(11'd16, 1'b0, 1'b0, 11'd1, 2'd0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pt_decode_stream.md
Name: pt_decode_stream

Overview:
- Decode engine; the inverse of the plaintext-add path.
- Takes a decrypted phase polynomial (B + A·s mod q), one coefficient per handshake.
- Recovers each plaintext slot as Γ[i] = round(x/Δ) mod T and streams the results out with frame framing.
- Sits between the decryption multiply-accumulate stage and the plaintext sink/compare logic.

Parameters:
- N, N_SLOTS_L: coefficients per frame.
- W, W_BITS_L: coefficient width.
- QP, Q_MOD_L: ciphertext modulus q.
- DELTAP, DELTA_L: scale Δ; must be nonzero.
- TP, Q_MOD_L/DELTA_L (integer divide): plaintext modulus T.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  engine can accept a coefficient.
- in_coef  in  W  phase coefficient x; legal range 0..Q-1.
- in_last  in  1  producer marks the final coefficient of a frame.
- out_valid  out  1  decoded coefficient valid.
- out_ready  in  1  consumer accepts the decoded coefficient.
- out_coef  out  W  decoded plaintext slot, 0..T-1.
- out_last  out  1  decoded coefficient is slot N-1.
- out_idx  out  $clog2(N)  slot index of out_coef.
- err_range  out  1  sticky: an input with in_coef ≥ Q was seen.
- err_frame  out  1  sticky: in_last disagreed with the internal index.
- err_clr  in  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0 during reset, out_valid=0, out_coef=0, out_last=0, out_idx=0, index counter=0, err_range=0, err_frame=0, divider registers=0.
- First cycle after reset release: in_ready=1.
- FSM states: IDLE, DIV, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch xr = in_coef + floor(Δ/2) into a W+1-bit dividend.
  - Compare latched in_last against (idx==N-1); on mismatch set err_frame.
  - If in_coef ≥ Q: set err_range and force the result to 0.
  - Clear the bit counter; go to DIV.
- DIV:
  - in_ready=0.
  - Restoring division, one quotient bit per cycle, MSB first, W+1 cycles.
  - Remainder register is W+1 bits; the subtract uses a W+2-bit compare to avoid overflow.
  - After the final bit, apply the wrap: if quotient ≥ T, subtract T once.
  - The single subtract is sufficient because x < Q ⇒ quotient ≤ T.
  - Load out_coef, set out_idx=idx and out_last=(idx==N-1), set out_valid=1; go to HOLD.
- HOLD:
  - out_valid stays 1; out_coef, out_last and out_idx hold stable until out_ready.
  - On out_valid&out_ready: out_valid→0 next cycle; idx increments, wrapping N-1→0; go to IDLE.
  - in_ready returns to 1 in that same next cycle.
- Latency and throughput:
  - Latency from input handshake to out_valid: W+2 cycles.
  - Throughput: one coefficient per W+3 cycles minimum.
  - No input is accepted while DIV or HOLD is active.
- err_frame:
  - A mismatch does not resync idx.
  - Exception: when in_last=1 arrives early, idx still resets to 0 after that coefficient is consumed, so the next frame realigns.
- Error flags: sticky until err_clr=1 or reset.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag reads 1).
- out_valid may only rise in DIV→HOLD; it is never withdrawn without out_ready.
- Reset mid-division or in HOLD: the partial result is discarded, with no output.
- Output arithmetic is unsigned; no signed interpretation of x (phase is already in [0,q)).

Test Plan:
- Override TB parameters to Q=1024, Δ=16, T=64, W=11, N=4.
- Reset check: assert rst_n=0 asynchronously mid-DIV → all outputs 0 immediately, no output appears after release.
- Rounding: inputs 0, 7, 8, 33 → out_coef 0, 0, 1, 2; out_valid rises exactly W+2 cycles after each handshake.
- Wrap: input 1016 → (1024)/16=64 → out_coef 0; input 1000 → out_coef 63.
- Framing: 4 consecutive inputs with in_last on the 4th → out_idx 0..3, out_last only on idx 3, err_frame=0.
  - Then repeat with in_last on the 2nd → err_frame=1 and idx returns to 0.
- Backpressure: hold out_ready=0 for 20 cycles in HOLD → out_coef/out_idx stable, in_ready=0 throughout, single transfer on release.
- Range error: in_coef=1030 → err_range=1, out_coef=0.
  - err_clr pulse → flag 0.
  - err_clr coincident with another bad input → flag stays 1.
